// File: rtl/fifo_pkt_unpacker.sv
// Reads length-prefixed packets from a first-word-fall-through byte FIFO, forwards the
// payload on a valid/ready stream with sop/eop markers, and checks each packet's checksum.
module fifo_pkt_unpacker #(
    parameter int MAX_LEN = 64
) (
    input  logic        rclk,
    input  logic        rrst_n,
    input  logic [7:0]  rdata,
    input  logic        rempty,
    output logic        rinc,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {HDR, PAYLOAD, CSUM, DROP} state_t;

    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    state_t      state, state_next;
    logic [8:0]  remaining;   // wide enough for L+1 when an oversize packet is skipped
    logic [7:0]  sum;
    logic        first;
    logic        len_zero, len_over;

    assign len_zero = (rdata == 8'h00);
    assign len_over = ({1'b0, rdata} > MAX_LEN_W);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= HDR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rinc       = 1'b0;
        if (rrst_n) begin
            case (state)
                HDR: begin
                    rinc = !rempty;
                    if (rinc && len_over) begin
                        state_next = DROP;
                    end else if (rinc && !len_zero) begin
                        state_next = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    rinc = !rempty && (!out_valid || out_ready);
                    if (rinc && remaining == 9'd1) begin
                        state_next = CSUM;
                    end
                end
                CSUM: begin
                    rinc = !rempty;
                    if (rinc) begin
                        state_next = HDR;
                    end
                end
                DROP: begin
                    rinc = !rempty;
                    if (rinc && remaining == 9'd1) begin
                        state_next = HDR;
                    end
                end
                default: state_next = HDR;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            remaining <= 9'd0;
            sum       <= 8'h00;
            first     <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            pkt_cnt   <= 16'h0000;
            err_cnt   <= 16'h0000;
        end else begin
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            // A load later in this block overrides the clear, giving bubble-free streaming.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (rinc) begin
                case (state)
                    HDR: begin
                        if (len_zero) begin
                            pkt_done <= 1'b1;
                            pkt_err  <= 1'b1;
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                        end else if (len_over) begin
                            remaining <= {1'b0, rdata} + 9'd1;
                        end else begin
                            remaining <= {1'b0, rdata};
                            sum       <= 8'h00;
                            first     <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        out_data  <= rdata;
                        out_valid <= 1'b1;
                        out_sop   <= first;
                        out_eop   <= (remaining == 9'd1);
                        first     <= 1'b0;
                        sum       <= sum + rdata;
                        remaining <= remaining - 9'd1;
                    end
                    CSUM: begin
                        pkt_done <= 1'b1;
                        pkt_err  <= (rdata != sum);
                        if (rdata == sum) begin
                            if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
                        end else begin
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                        end
                    end
                    DROP: begin
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            pkt_done <= 1'b1;
                            pkt_err  <= 1'b1;
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_pkt_unpacker.sv
// Directed bench for fifo_pkt_unpacker: a queue-backed FIFO feeds packets, and a
// packet-position model predicts every output on each cycle.
module tb_fifo_pkt_unpacker;

    localparam int MAX_LEN = 64;

    logic        rclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic        rempty = 1'b1;
    logic        rinc;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop;
    logic        out_eop;
    logic        pkt_done;
    logic        pkt_err;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    fifo_pkt_unpacker #(.MAX_LEN(MAX_LEN)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 rclk = ~rclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] fifo_q[$];
    logic [9:0] got_q[$];   // {sop, eop, data} of each transferred byte
    logic       done_q[$];  // pkt_err of each pkt_done pulse

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-position model: pos 0 is the header, 1..plen the payload, plen+1 the checksum.
    int         pos = 0;
    int         plen = 0;
    bit         drop = 0;
    logic [7:0] psum = 8'h00;
    logic [7:0] e_data = 8'h00;
    bit         e_valid = 0, e_sop = 0, e_eop = 0, e_done = 0, e_err = 0;
    int         e_pcnt = 0, e_ecnt = 0;

    always @(negedge rclk) begin
        if (!rrst_n) begin
            chk("rst_rinc", int'(rinc), 0);
            chk("rst_data", int'(out_data), 0);
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_sop", int'(out_sop), 0);
            chk("rst_eop", int'(out_eop), 0);
            chk("rst_done", int'(pkt_done), 0);
            chk("rst_err", int'(pkt_err), 0);
            chk("rst_pkt_cnt", int'(pkt_cnt), 0);
            chk("rst_err_cnt", int'(err_cnt), 0);
            pos = 0; plen = 0; drop = 0; psum = 8'h00;
            e_data = 8'h00; e_valid = 0; e_sop = 0; e_eop = 0; e_done = 0; e_err = 0;
            e_pcnt = 0; e_ecnt = 0;
        end else begin
            bit in_pay;
            bit e_rinc;
            chk("out_valid", int'(out_valid), int'(e_valid));
            if (e_valid) begin
                chk("out_data", int'(out_data), int'(e_data));
                chk("out_sop", int'(out_sop), int'(e_sop));
                chk("out_eop", int'(out_eop), int'(e_eop));
            end
            chk("pkt_done", int'(pkt_done), int'(e_done));
            if (e_done) chk("pkt_err", int'(pkt_err), int'(e_err));
            chk("pkt_cnt", int'(pkt_cnt), e_pcnt);
            chk("err_cnt", int'(err_cnt), e_ecnt);
            if (out_valid && out_ready) got_q.push_back({out_sop, out_eop, out_data});
            if (pkt_done) done_q.push_back(pkt_err);

            in_pay = (pos >= 1) && !drop && (pos <= plen);
            e_rinc = !rempty && !(in_pay && e_valid && !out_ready);
            chk("rinc", int'(rinc), int'(e_rinc));

            e_done = 0;
            e_err  = 0;
            if (e_valid && out_ready) e_valid = 0;
            if (e_rinc) begin
                if (pos == 0) begin
                    plen = int'(rdata);
                    if (plen == 0) begin
                        e_done = 1; e_err = 1;
                        if (e_ecnt < 65535) e_ecnt++;
                    end else begin
                        drop = (plen > MAX_LEN);
                        psum = 8'h00;
                        pos  = 1;
                    end
                end else if (pos <= plen && !drop) begin
                    e_data = rdata; e_valid = 1;
                    e_sop = (pos == 1); e_eop = (pos == plen);
                    psum = psum + rdata;
                    pos++;
                end else if (pos == plen + 1) begin
                    e_done = 1;
                    e_err  = drop || (rdata != psum);
                    if (e_err) begin
                        if (e_ecnt < 65535) e_ecnt++;
                    end else begin
                        if (e_pcnt < 65535) e_pcnt++;
                    end
                    pos = 0; drop = 0;
                end else begin
                    pos++;
                end
            end
        end
    end

    // Inputs only change 1 time unit after a rising edge.
    task automatic drive();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? 8'h00 : fifo_q[0];
    endtask

    task automatic cycle();
        logic rinc_s;
        @(negedge rclk);
        rinc_s = rinc;
        @(posedge rclk);
        if (rinc_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
        drive();
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        drive();
    endtask

    task automatic push_pkt(input logic [7:0] bytes[$]);
        foreach (bytes[i]) fifo_q.push_back(bytes[i]);
        drive();
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        while ((fifo_q.size() != 0 || out_valid) && n < max) begin
            cycle();
            n++;
        end
        if (n >= max) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got %0d cycles, want < %0d", name, n, max);
        end
        repeat (3) cycle();
    endtask

    task automatic clear();
        got_q.delete();
        done_q.delete();
    endtask

    task automatic expect_bytes(input string name, input logic [9:0] exp[$]);
        chk({name, "_count"}, got_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < got_q.size()) chk({name, "_byte"}, int'(got_q[i]), int'(exp[i]));
        end
    endtask

    task automatic expect_done(input string name, input logic exp[$]);
        chk({name, "_pulses"}, done_q.size(), exp.size());
        foreach (exp[i]) begin
            if (i < done_q.size()) chk({name, "_err"}, int'(done_q[i]), int'(exp[i]));
        end
    endtask

    initial begin
        // Reset with a non-empty FIFO
        push_pkt('{8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
        repeat (3) cycle();
        chk("lit_rst_rinc", int'(rinc), 0);
        chk("lit_rst_valid", int'(out_valid), 0);
        rrst_n = 1'b1;
        #1;
        chk("lit_release_rinc", int'(rinc), 1);

        // Good packet at full rate
        clear();
        drain("good", 50);
        expect_bytes("good", '{10'h211, 10'h022, 10'h133});
        expect_done("good", '{1'b0});
        chk("lit_good_pkt_cnt", int'(pkt_cnt), 1);

        // Backpressure: out_ready low for 5 cycles after the first byte
        clear();
        push_pkt('{8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                cycle();
                n++;
            end
            if (n >= 20) begin
                n_cmp++; n_bad++;
                $display("FAIL bp_wait_timeout: got %0d cycles, want < 20", n);
            end
        end
        out_ready = 1'b0;
        repeat (5) begin
            cycle();
            chk("lit_stall_data", int'(out_data), 8'h11);
            chk("lit_stall_rinc", int'(rinc), 0);
        end
        out_ready = 1'b1;
        drain("bp", 50);
        expect_bytes("bp", '{10'h211, 10'h022, 10'h133});
        expect_done("bp", '{1'b0});
        chk("lit_bp_pkt_cnt", int'(pkt_cnt), 2);

        // Bad checksum
        clear();
        push_pkt('{8'h02, 8'hAA, 8'h55, 8'h00});
        drain("badcs", 50);
        expect_bytes("badcs", '{10'h2AA, 10'h155});
        expect_done("badcs", '{1'b1});
        chk("lit_badcs_err_cnt", int'(err_cnt), 1);
        chk("lit_badcs_pkt_cnt", int'(pkt_cnt), 2);

        // Zero length followed by a good packet
        clear();
        push_pkt('{8'h00, 8'h01, 8'h5A, 8'h5A});
        drain("len0", 50);
        expect_bytes("len0", '{10'h35A});
        expect_done("len0", '{1'b1, 1'b0});
        chk("lit_len0_err_cnt", int'(err_cnt), 2);
        chk("lit_len0_pkt_cnt", int'(pkt_cnt), 3);

        // Oversize length: 0x50 plus 81 bytes dropped, then a good packet
        clear();
        push(8'h50);
        for (int i = 0; i < 81; i++) push(8'((i * 7 + 3) & 8'hFF));
        push_pkt('{8'h02, 8'h01, 8'h02, 8'h03});
        drain("oversize", 200);
        expect_bytes("oversize", '{10'h201, 10'h102});
        expect_done("oversize", '{1'b1, 1'b0});
        chk("lit_over_err_cnt", int'(err_cnt), 3);
        chk("lit_over_pkt_cnt", int'(pkt_cnt), 4);

        // Sparse FIFO with an L=1 packet
        clear();
        begin
            logic [7:0] sparse[3];
            sparse = '{8'h01, 8'h7F, 8'h7F};
            foreach (sparse[i]) begin
                push(sparse[i]);
                repeat (4) cycle();
            end
        end
        drain("sparse", 50);
        expect_bytes("sparse", '{10'h37F});
        expect_done("sparse", '{1'b0});
        chk("lit_sparse_pkt_cnt", int'(pkt_cnt), 5);

        // Reset mid-packet aborts it and clears the counts
        clear();
        push_pkt('{8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
        repeat (3) cycle();
        rrst_n = 1'b0;
        fifo_q.delete();
        drive();
        repeat (2) cycle();
        chk("lit_midrst_pkt_cnt", int'(pkt_cnt), 0);
        chk("lit_midrst_err_cnt", int'(err_cnt), 0);
        rrst_n = 1'b1;
        clear();
        push_pkt('{8'h01, 8'h42, 8'h42});
        drain("after_rst", 50);
        expect_bytes("after_rst", '{10'h342});
        expect_done("after_rst", '{1'b0});
        chk("lit_after_rst_pkt_cnt", int'(pkt_cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
